// File: rtl/patternbuf_pkg.sv
// patternbuf_pkg: shared sizes, controller state type and the binary-to-one-hot helper.
package patternbuf_pkg;
    localparam int BUFFER_WIDTH = 8;
    localparam int BUFFER_SIZE  = 32;
    localparam int ADDR_WIDTH   = $clog2(BUFFER_SIZE);
    localparam int SHIFT_LEN    = BUFFER_SIZE * BUFFER_WIDTH;
    localparam int CNT_W        = $clog2(SHIFT_LEN);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} pbc_state_t;

    // Addresses beyond the buffer decode to all-zero so they select nothing.
    function automatic logic [BUFFER_SIZE-1:0] onehot(input logic [ADDR_WIDTH-1:0] addr);
        onehot = '0;
        if (int'(addr) < BUFFER_SIZE) onehot[addr] = 1'b1;
    endfunction
endpackage

// File: rtl/patternbuf_ctrl_if.sv
// patternbuf_ctrl_if: requester-side read/write/reload bus of the pattern buffer controller.
interface patternbuf_ctrl_if;
    import patternbuf_pkg::*;
    logic                    rd_en;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic                    rd_valid;
    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [BUFFER_WIDTH-1:0] wr_data;
    logic                    wr_stall;
    logic                    load_start;
    logic                    sin_in;
    logic                    load_busy;
    logic                    load_done;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, load_start, sin_in,
        input  rd_valid, wr_stall, load_busy, load_done
    );
    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, load_start, sin_in,
        output rd_valid, wr_stall, load_busy, load_done
    );
endinterface

// File: rtl/patternbuf.sv
// patternbuf: word-addressed pattern store whose flops also form one serial shift chain.
module patternbuf
    import patternbuf_pkg::*;
(
    input  logic                    clk,
    input  logic [BUFFER_SIZE-1:0]  fieldp,
    input  logic [BUFFER_SIZE-1:0]  fieldwp,
    input  logic [BUFFER_WIDTH-1:0] field_in,
    input  logic                    field_write,
    input  logic                    ssel,
    input  logic                    sin,
    output logic [BUFFER_WIDTH-1:0] field_byte,
    output logic                    sout
);
    logic [SHIFT_LEN-1:0] bits;

    // sin enters word 0 bit 0; the oldest bit leaves from word 31 bit 7.
    always_ff @(posedge clk)
        if (ssel) bits <= {bits[SHIFT_LEN-2:0], sin};
        else if (field_write)
            for (int i = 0; i < BUFFER_SIZE; i++)
                if (fieldwp[i]) bits[i*BUFFER_WIDTH +: BUFFER_WIDTH] <= field_in;

    always_comb begin
        field_byte = '0;
        for (int i = 0; i < BUFFER_SIZE; i++)
            if (fieldp[i]) field_byte = field_byte | bits[i*BUFFER_WIDTH +: BUFFER_WIDTH];
    end

    assign sout = bits[SHIFT_LEN-1];
endmodule

// File: rtl/patternbuf_onehot.sv
// patternbuf_onehot: binary word address to one-hot pointer, out-of-range gives zero.
module patternbuf_onehot
    import patternbuf_pkg::*;
(
    input  logic [ADDR_WIDTH-1:0]  addr,
    output logic [BUFFER_SIZE-1:0] hot
);
    assign hot = onehot(addr);
endmodule

// File: rtl/patternbuf_ctrl.sv
// patternbuf_ctrl: turns read/write requests into one-hot pointers and write strobes,
// and sequences the full serial reload while keeping writes off the shift cycles.
module patternbuf_ctrl
    import patternbuf_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    patternbuf_ctrl_if.slave        bus,
    output logic [BUFFER_SIZE-1:0]  fieldp,
    output logic [BUFFER_SIZE-1:0]  fieldwp,
    output logic [BUFFER_WIDTH-1:0] field_in,
    output logic                    field_write,
    output logic                    ssel,
    output logic                    sin
);
    pbc_state_t             state, state_nx;
    logic [CNT_W-1:0]       count;
    logic                   start, wr_ok, last;
    logic [BUFFER_SIZE-1:0] rd_hot, wr_hot;

    patternbuf_onehot u_rd (.addr(bus.rd_addr), .hot(rd_hot));
    patternbuf_onehot u_wr (.addr(bus.wr_addr), .hot(wr_hot));

    always_ff @(posedge clk)
        if (reset) state <= IDLE;
        else state <= state_nx;

    always_comb
        state_nx = (state == IDLE)  ? (bus.load_start ? SHIFT : IDLE) :
                   (state == SHIFT) ? (last ? DONE : SHIFT) : IDLE;

    // A starting reload claims the cycle, so a same-cycle write waits.
    always_comb begin
        start         = (state == IDLE) & bus.load_start;
        last          = count == CNT_W'(SHIFT_LEN - 1);
        bus.load_busy = state == SHIFT;
        bus.wr_stall  = bus.load_busy | start;
        wr_ok         = bus.wr_en & ~bus.wr_stall;
    end

    always_ff @(posedge clk)
        if (reset) begin
            count         <= '0;
            fieldp        <= BUFFER_SIZE'(1);
            fieldwp       <= '0;
            field_in      <= '0;
            field_write   <= 1'b0;
            ssel          <= 1'b0;
            sin           <= 1'b0;
            bus.rd_valid  <= 1'b0;
            bus.load_done <= 1'b0;
        end else begin
            count         <= bus.load_busy ? count + 1'b1 : '0;
            fieldp        <= bus.rd_en ? rd_hot : fieldp;
            fieldwp       <= wr_ok ? wr_hot : '0;
            field_in      <= wr_ok ? bus.wr_data : field_in;
            field_write   <= wr_ok;
            ssel          <= bus.load_busy;
            sin           <= bus.load_busy & bus.sin_in;
            bus.rd_valid  <= bus.rd_en & ~bus.load_busy & ~start;
            bus.load_done <= state == DONE;
        end
endmodule

// File: tb/tb_patternbuf_ctrl.sv
// tb_patternbuf_ctrl: directed checks of the controller driving a real patternbuf.
module tb_patternbuf_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] fieldp, fieldwp;
    logic [7:0]  field_in, field_byte;
    logic        field_write, ssel, sin, sout;
    int          n_tests = 0, n_fail = 0, overlap = 0;
    int          busy, dones, stalls;

    patternbuf_ctrl_if bus();

    patternbuf_ctrl dut (.clk(clk), .reset(reset), .bus(bus), .fieldp(fieldp), .fieldwp(fieldwp),
        .field_in(field_in), .field_write(field_write), .ssel(ssel), .sin(sin));

    patternbuf u_buf (.clk(clk), .fieldp(fieldp), .fieldwp(fieldwp), .field_in(field_in),
        .field_write(field_write), .ssel(ssel), .sin(sin), .field_byte(field_byte), .sout(sout));

    always #5 clk = ~clk;

    always @(negedge clk) if (ssel & field_write) overlap++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [4:0] a, input logic [7:0] exp, input string tag);
        bus.rd_en = 1'b1;
        bus.rd_addr = a;
        tick();
        bus.rd_en = 1'b0;
        chk({tag, "_valid"}, 32'(bus.rd_valid), 32'd1);
        chk(tag, 32'(field_byte), 32'(exp));
    endtask

    // Reload with a single leading 1; returns busy cycles and load_done pulses seen.
    task automatic do_load(output int nb, output int nd);
        nb = 0;
        nd = 0;
        bus.load_start = 1'b1;
        bus.sin_in = 1'b1;
        tick();
        bus.load_start = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (bus.load_busy) nb++;
            if (bus.load_done) nd++;
            tick();
            bus.sin_in = 1'b0;
        end
    endtask

    initial begin
        bus.rd_en = 0; bus.rd_addr = 0; bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0;
        bus.load_start = 0; bus.sin_in = 0;
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("rst_fieldp", fieldp, 32'h1);
        chk("rst_fieldwp", fieldwp, 32'h0);
        chk("rst_fw", 32'(field_write), 32'd0);
        chk("rst_ssel", 32'(ssel), 32'd0);
        chk("rst_done", 32'(bus.load_done), 32'd0);
        chk("rst_rdv", 32'(bus.rd_valid), 32'd0);
        chk("rst_busy", 32'(bus.load_busy), 32'd0);

        bus.wr_en = 1; bus.wr_addr = 5; bus.wr_data = 8'hA5;
        #1 chk("w5_stall", 32'(bus.wr_stall), 32'd0);
        tick();
        bus.wr_en = 0;
        chk("w5_fw", 32'(field_write), 32'd1);
        chk("w5_fieldwp", fieldwp, 32'h20);
        chk("w5_field_in", 32'(field_in), 32'hA5);
        rd(5, 8'hA5, "r5");
        chk("r5_fieldp", fieldp, 32'h20);
        chk("r5_fw_off", 32'(field_write), 32'd0);
        tick();
        chk("rdv_drop", 32'(bus.rd_valid), 32'd0);

        bus.wr_en = 1; bus.wr_addr = 0; bus.wr_data = 8'h11;
        tick();
        chk("b2b0_fw", 32'(field_write), 32'd1);
        chk("b2b0_wp", fieldwp, 32'h1);
        bus.wr_addr = 1; bus.wr_data = 8'h22;
        tick();
        chk("b2b1_fw", 32'(field_write), 32'd1);
        chk("b2b1_wp", fieldwp, 32'h2);
        bus.wr_addr = 31; bus.wr_data = 8'h33;
        tick();
        chk("b2b31_fw", 32'(field_write), 32'd1);
        chk("b2b31_wp", fieldwp, 32'h8000_0000);
        bus.wr_en = 0;
        tick();
        chk("b2b_end_fw", 32'(field_write), 32'd0);
        rd(0, 8'h11, "r0");
        rd(1, 8'h22, "r1");
        rd(31, 8'h33, "r31");
        rd(5, 8'hA5, "r5b");

        bus.load_start = 1;
        #1 chk("ld_stall", 32'(bus.wr_stall), 32'd1);
        bus.load_start = 0;
        do_load(busy, dones);
        chk("ld_busy", busy, 256);
        chk("ld_done", dones, 1);
        chk("ld_sout", 32'(sout), 32'd1);
        rd(31, 8'h80, "ld_r31");
        rd(0, 8'h00, "ld_r0");
        rd(5, 8'h00, "ld_r5");

        bus.wr_en = 1; bus.wr_addr = 2; bus.wr_data = 8'h5A;
        tick();
        bus.load_start = 1; bus.wr_addr = 3; bus.wr_data = 8'hC3; bus.sin_in = 0;
        #1 chk("pri_stall", 32'(bus.wr_stall), 32'd1);
        chk("pri_prior_fw", 32'(field_write), 32'd1);
        chk("pri_prior_wp", fieldwp, 32'h4);
        tick();
        bus.load_start = 0;
        stalls = 0;
        for (int i = 0; i < 300 && bus.wr_stall; i++) begin
            stalls++;
            tick();
        end
        chk("pri_stalls", stalls, 256);
        chk("pri_not_busy", 32'(bus.load_busy), 32'd0);
        tick();
        bus.wr_en = 0;
        chk("pri_fw", 32'(field_write), 32'd1);
        chk("pri_wp", fieldwp, 32'h8);
        chk("pri_ssel", 32'(ssel), 32'd0);
        chk("pri_done", 32'(bus.load_done), 32'd1);
        rd(3, 8'hC3, "pri_r3");
        rd(2, 8'h00, "pri_r2");

        bus.load_start = 1; bus.sin_in = 1;
        tick();
        bus.load_start = 0;
        for (int i = 0; i < 100; i++) tick();
        chk("mid_busy", 32'(bus.load_busy), 32'd1);
        reset = 1;
        tick();
        reset = 0;
        chk("mid_idle", 32'(bus.load_busy), 32'd0);
        chk("mid_ssel", 32'(ssel), 32'd0);
        chk("mid_fieldp", fieldp, 32'h1);
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.load_done) dones++;
            tick();
        end
        chk("mid_no_done", dones, 0);
        do_load(busy, dones);
        chk("re_busy", busy, 256);
        chk("re_done", dones, 1);
        chk("re_sout", 32'(sout), 32'd1);
        rd(31, 8'h80, "re_r31");
        rd(3, 8'h00, "re_r3");

        chk("no_overlap", overlap, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
